// File: rtl/fan_ctrl_core.sv
// Fan controller core: N-level speed, timer presets, breeze gusting, proximity
// auto-pause with hysteresis, and a soft-ramped registered PWM output.
module fan_ctrl_core #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned SPEED_LEVELS = 4,
  parameter int unsigned TIMER_STEPS  = 4,
  parameter int unsigned TIMER_STEP_S = 60,
  parameter int unsigned RAMP_DIV     = 1024,
  parameter int unsigned BREEZE_S     = 3,
  parameter int unsigned NEAR_CM      = 20,
  parameter int unsigned HYST_CM      = 5
) (
  input  logic                            clk,
  input  logic                            reset_p,
  input  logic                            btn_speed,
  input  logic                            btn_timer,
  input  logic                            btn_mode,
  input  logic [11:0]                     distance,
  input  logic                            distance_valid,
  output logic                            motor_pwm,
  output logic [PWM_BITS-1:0]             duty,
  output logic [$clog2(SPEED_LEVELS)-1:0] speed_level,
  output logic [$clog2(TIMER_STEPS)-1:0]  timer_sel,
  output logic [15:0]                     remain_s,
  output logic                            breeze,
  output logic                            paused,
  output logic                            timer_done
);

  localparam int unsigned MAXD = (1 << PWM_BITS) - 1;
  localparam int unsigned LW   = $clog2(SPEED_LEVELS);
  localparam int unsigned TW   = $clog2(TIMER_STEPS);
  localparam int unsigned PW   = $clog2(CLK_HZ + 1);
  localparam int unsigned RW   = $clog2(RAMP_DIV + 1);
  localparam int unsigned BW   = $clog2(BREEZE_S + 1);

  typedef enum logic {ST_RUN = 1'b0, ST_PAUSE = 1'b1} prox_state_t;

  prox_state_t         state, state_next;
  logic [PW-1:0]       presc;
  logic                tick;
  logic [RW-1:0]       rdiv;
  logic                ramp_step;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] level_duty;
  logic [PWM_BITS-1:0] target;
  logic [BW-1:0]       bcnt;
  logic                phase_hi;
  logic [TW-1:0]       sel_next;
  logic                count_en;
  logic                expire;

  assign tick      = (presc == PW'(CLK_HZ - 1));
  assign ramp_step = (rdiv == RW'(RAMP_DIV - 1));
  assign sel_next  = (timer_sel == TW'(TIMER_STEPS - 1)) ? '0 : timer_sel + TW'(1);
  assign count_en  = tick && (remain_s != '0) && (speed_level != '0) && !paused;
  assign expire    = count_en && (remain_s == 16'd1);

  // Product is formed at 32 bits before the divide so no precision is lost.
  always_comb begin
    level_duty = PWM_BITS'((32'(speed_level) * 32'(MAXD)) / 32'(SPEED_LEVELS - 1));
    target     = '0;
    if (speed_level != '0 && !paused) begin
      if (breeze && !phase_hi) target = level_duty >> 1;
      else                     target = level_duty;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p)                presc <= '0;
    else if (btn_timer || tick) presc <= '0;
    else                        presc <= presc + PW'(1);
  end

  // btn_timer overrides expiry entirely; expiry overrides btn_speed.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      speed_level <= '0;
      timer_sel   <= '0;
      remain_s    <= '0;
      timer_done  <= 1'b0;
    end else begin
      timer_done <= 1'b0;
      if (btn_speed)
        speed_level <= (speed_level == LW'(SPEED_LEVELS - 1)) ? '0 : speed_level + LW'(1);
      if (btn_timer) begin
        timer_sel <= sel_next;
        remain_s  <= 16'(32'(sel_next) * 32'(TIMER_STEP_S));
      end else if (count_en) begin
        remain_s <= remain_s - 16'd1;
        if (expire) begin
          speed_level <= '0;
          timer_sel   <= '0;
          timer_done  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      breeze   <= 1'b0;
      phase_hi <= 1'b1;
      bcnt     <= '0;
    end else if (btn_mode) begin
      breeze   <= ~breeze;
      phase_hi <= 1'b1;
      bcnt     <= '0;
    end else if (tick && breeze && speed_level != '0) begin
      if (bcnt == BW'(BREEZE_S - 1)) begin
        bcnt     <= '0;
        phase_hi <= ~phase_hi;
      end else begin
        bcnt <= bcnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      rdiv <= '0;
      duty <= '0;
    end else begin
      rdiv <= ramp_step ? '0 : rdiv + RW'(1);
      if (ramp_step) begin
        if (duty < target)      duty <= duty + PWM_BITS'(1);
        else if (duty > target) duty <= duty - PWM_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      pwm_cnt   <= '0;
      motor_pwm <= 1'b0;
    end else begin
      pwm_cnt   <= (pwm_cnt == PWM_BITS'(MAXD - 1)) ? '0 : pwm_cnt + PWM_BITS'(1);
      motor_pwm <= (pwm_cnt < duty);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) state <= ST_RUN;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (distance_valid) begin
      case (state)
        ST_RUN:   if (distance < 12'(NEAR_CM))             state_next = ST_PAUSE;
        ST_PAUSE: if (distance >= 12'(NEAR_CM + HYST_CM))  state_next = ST_RUN;
        default:                                           state_next = ST_RUN;
      endcase
    end
  end

  always_comb begin
    paused = (state == ST_PAUSE);
  end

endmodule

// File: doc/fan_ctrl_core.md
# fan_ctrl_core

Parametrised fan controller core: the next-generation replacement for the fixed 3-level speed/timer logic in the multifunctional fan. Takes debounced one-cycle button strobes and the ultrasonic distance, and produces a soft-ramped motor PWM. Supports N speed levels, N timer presets, a breeze (gusting) mode and proximity auto-pause with hysteresis. Sits between the button debouncers/ultrasonic block and the motor driver pin and 7-segment/LED display logic.

## Interface
- CLK_HZ, 100_000_000, clock frequency; sets the 1 s tick
- PWM_BITS, 8, PWM resolution; MAXD = 2^PWM_BITS-1
- SPEED_LEVELS, 4, levels 0..SPEED_LEVELS-1, level 0 = off (>=2)
- TIMER_STEPS, 4, presets 0..TIMER_STEPS-1, preset 0 = no timer
- TIMER_STEP_S, 60, seconds per preset step
- RAMP_DIV, 1024, clocks per 1-LSB duty step (>=1)
- BREEZE_S, 3, seconds per breeze half-period
- NEAR_CM, 20, pause threshold; HYST_CM, 5, resume hysteresis
- clk  in  1  system clock
- reset_p  in  1  synchronous, active-high reset
- btn_speed, btn_timer, btn_mode  in  1 each  one-cycle strobes
- distance  in  12  distance in cm; distance_valid  in  1  one-cycle strobe
- motor_pwm  out  1  PWM to the motor driver
- duty  out  PWM_BITS  current ramped duty
- speed_level  out  clog2(SPEED_LEVELS)  selected level
- timer_sel  out  clog2(TIMER_STEPS)  selected preset
- remain_s  out  16  seconds remaining (0 when no timer)
- breeze, paused  out  1 each  mode/pause flags
- timer_done  out  1  one-cycle pulse at expiry

## Operation
- Reset: all outputs 0, tick prescaler 0, PWM counter 0, state RUN, breeze phase HIGH.
- btn_speed: level+1, wraps SPEED_LEVELS-1 -> 0.
- btn_timer: timer_sel+1 (wraps to 0). Loads remain_s = new_sel*TIMER_STEP_S and clears the prescaler.
- btn_mode: toggles breeze. Breeze phase is reset to HIGH and the breeze second counter to 0.
- Level duty: LD = floor(level*MAXD/(SPEED_LEVELS-1)). Constant-divisor arithmetic is done at full width with no truncation before the divide.
- Target duty:
  - 0 if level==0 or paused.
  - Otherwise, in breeze mode during the LOW phase: LD>>1.
  - Otherwise: LD.
- Breeze phase toggles every BREEZE_S ticks while breeze==1 and level!=0.
- Tick: one-cycle pulse when the prescaler reaches CLK_HZ-1; the prescaler then wraps to 0.
- Countdown:
  - On a tick with remain_s!=0 and level!=0: remain_s-1.
  - Transition to 0: level<=0, timer_sel<=0, timer_done=1 for 1 cycle.
  - Countdown freezes while level==0 or paused.
- Proximity FSM, evaluated only on distance_valid:
  - RUN -> PAUSE when distance < NEAR_CM.
  - PAUSE -> RUN when distance >= NEAR_CM+HYST_CM.
  - Values in between hold the current state.
  - paused = (state==PAUSE).
- Ramp: every RAMP_DIV clocks, duty moves 1 LSB toward the target. Duty holds once equal to the target.
- PWM:
  - Counter runs 0..MAXD-1 and wraps.
  - motor_pwm = (cnt < duty), so duty=MAXD gives constant high and duty=0 gives constant low.
  - motor_pwm is registered.
- Simultaneous events:
  - Timer expiry beats btn_speed in the same cycle (level ends 0).
  - btn_timer in the expiry cycle wins: the new preset loads and there is no timer_done.
  - btn_speed and btn_timer in the same cycle both apply.
- reset_p mid-ramp or mid-countdown returns everything to reset values on the next edge.

## Timing
- Strobe effects on speed_level, timer_sel, remain_s and breeze are visible 1 cycle after the strobe edge.
- Target duty is combinational from registered state. duty begins moving at the next RAMP_DIV boundary; a full 0->MAXD sweep takes MAXD*RAMP_DIV cycles.
- motor_pwm lags the cnt/duty compare by 1 cycle. PWM period is MAXD cycles.
- paused updates 1 cycle after distance_valid.
- timer_done asserts in the same cycle that remain_s shows 0.

## Test plan
Unless stated, parameters are CLK_HZ=10, PWM_BITS=4 (MAXD=15), SPEED_LEVELS=4, RAMP_DIV=1, TIMER_STEP_S=2, BREEZE_S=1.
- Speed wrap: after reset, 4 btn_speed strobes -> level 1,2,3,0. At level 2, duty ramps 0->10 in 10 cycles and motor_pwm is high 10 of every 15 cycles.
- Timer expiry: level 3 plus 2 btn_timer strobes -> remain_s=4. After 40 cycles, remain_s=0, timer_done pulses once, level=0, timer_sel=0, and duty ramps to 0.
- Proximity hysteresis: level 3 with distance 19 -> paused=1 and duty ramps to 0. Distance 22 -> stays paused. Distance 25 -> resumes and ramps back to 15. Countdown is frozen throughout the pause.
- Breeze: level 2 plus btn_mode -> target alternates 10/5 every 10 cycles. A second btn_mode returns a constant target of 10.
- Collision: btn_speed in the expiry cycle -> level 0. btn_timer in the expiry cycle -> new preset loaded and no timer_done.
- Reset mid-ramp: assert reset_p at duty=7 -> next edge shows all outputs 0 and motor_pwm low.
